// File: rtl/frame_dump_streamer_pkg.sv
// Shared constants for the frame dump streamer: state encoding, ASCII codes, nibble formatter.
package frame_dump_streamer_pkg;

  localparam int unsigned DEF_PX_WIDTH  = 80;
  localparam int unsigned DEF_PX_HEIGHT = 60;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_NL   = 8'h0A;
  localparam logic [7:0] ASCII_A    = 8'h41;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_PIXELS,
    S_STATUS
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'b0, n};
    else           return ASCII_A + {4'b0, n - 4'd10};
  endfunction

endpackage

// File: rtl/frame_dump_streamer_skid.sv
// Two-entry skid FIFO holding ASCII pixel bytes between the framebuffer read port and the sink.
module pixel_skid_fifo (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] slot0, slot1;
  logic [1:0] cnt;
  logic       do_pop, do_push;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= din;
          else             slot1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) slot0 <= din;
          else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/frame_dump_streamer.sv
// Per-frame ASCII dump of the framebuffer plus a score/perfect status record on a valid/ready stream.
module frame_dump_streamer
  import frame_dump_streamer_pkg::*;
#(
  parameter int unsigned PX_WIDTH  = DEF_PX_WIDTH,
  parameter int unsigned PX_HEIGHT = DEF_PX_HEIGHT,
  parameter int unsigned PIX_BITS  = 3,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [3:0]          decim,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PIX_BITS-1:0] mem_data,
  input  logic [15:0]         score,
  input  logic                perfect,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_dumped,
  output logic [CNT_W-1:0]    frames_dropped
);

  localparam int unsigned NPIX  = PX_WIDTH * PX_HEIGHT;
  localparam int unsigned IDX_W = ADDR_W + 1;

  state_t             state_q, state_d;
  logic [3:0]         dec_cnt;
  logic [IDX_W-1:0]   pix_idx;
  logic [ADDR_W-1:0]  addr_q;
  logic               rd_pend;
  logic [2:0]         st_idx;
  logic [15:0]        score_q;
  logic               perfect_q;
  logic [7:0]         fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [1:0]         occ;
  logic [2:0]         load;
  logic               tick_hit, pix_done, pop, issue;

  assign tick_hit = frame_tick & enable & (dec_cnt == decim);
  assign busy     = (state_q != S_IDLE);
  assign pix_done = (pix_idx == IDX_W'(NPIX));
  assign pop      = (state_q == S_PIXELS) & out_valid & out_ready;
  assign occ      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // A byte leaving this cycle frees its slot now, which sustains one byte per clock.
  assign load     = 3'(occ) + 3'(rd_pend) - 3'(pop);
  assign issue    = (state_q == S_PIXELS) & !pix_done & (load < 3'd2);
  assign mem_addr = issue ? pix_idx[ADDR_W-1:0] : addr_q;

  pixel_skid_fifo u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (rd_pend),
    .pop   (pop),
    .din   (ASCII_ZERO + 8'(mem_data)),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      S_IDLE:   if (tick_hit) state_d = S_SNAP;
      S_SNAP:   state_d = S_PIXELS;
      S_PIXELS: begin
        if (!fifo_empty) begin
          out_valid = 1'b1;
          out_data  = fifo_dout;
        end
        if (pix_done && !rd_pend && occ == 2'd1 && out_ready) state_d = S_STATUS;
      end
      S_STATUS: begin
        out_valid = 1'b1;
        out_last  = (st_idx == 3'd7);
        case (st_idx)
          3'd0, 3'd5: out_data = ASCII_SP;
          3'd1:       out_data = hex_ascii(score_q[15:12]);
          3'd2:       out_data = hex_ascii(score_q[11:8]);
          3'd3:       out_data = hex_ascii(score_q[7:4]);
          3'd4:       out_data = hex_ascii(score_q[3:0]);
          3'd6:       out_data = ASCII_ZERO + {7'b0, perfect_q};
          default:    out_data = ASCII_NL;
        endcase
        if (out_ready && st_idx == 3'd7) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dec_cnt        <= '0;
      pix_idx        <= '0;
      addr_q         <= '0;
      rd_pend        <= 1'b0;
      st_idx         <= '0;
      score_q        <= '0;
      perfect_q      <= 1'b0;
      frames_dumped  <= '0;
      frames_dropped <= '0;
    end else begin
      if (state_q == S_IDLE && frame_tick && enable)
        dec_cnt <= (dec_cnt == decim) ? 4'd0 : dec_cnt + 4'd1;
      if (busy && tick_hit && frames_dropped != '1)
        frames_dropped <= frames_dropped + CNT_W'(1);
      if (state_q == S_SNAP) begin
        score_q   <= score;
        perfect_q <= perfect;
        pix_idx   <= '0;
        st_idx    <= '0;
      end
      if (issue) begin
        addr_q  <= pix_idx[ADDR_W-1:0];
        pix_idx <= pix_idx + IDX_W'(1);
      end
      rd_pend <= issue;
      if (state_q == S_STATUS && out_ready) begin
        st_idx <= st_idx + 3'd1;
        if (st_idx == 3'd7 && frames_dumped != '1)
          frames_dumped <= frames_dumped + CNT_W'(1);
      end
    end
  end

endmodule
